// File: rtl/spart_driver_if.sv
// SPART processor-side bus: spart_driver is the master, the SPART is the slave.
// Also carries the SPART rda/tbr status lines that the driver polls.
interface spart_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       rda;
    logic       tbr;

    modport master (
        output iocs, iorw, ioaddr, bus_out, bus_oe,
        input  bus_in, rda, tbr
    );

    modport slave (
        input  iocs, iorw, ioaddr, bus_out, bus_oe,
        output bus_in, rda, tbr
    );
endinterface

// File: rtl/spart_driver.sv
// SPART echo driver: programs the baud divisor from br_cfg, then echoes received bytes through a FIFO.
// Optional: define SPART_DRIVER_CASE_FOLD_EN to upper-case 'a'..'z' before they enter the FIFO.
module spart_driver #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     br_cfg,
    spart_driver_if.master bus,
    output logic [7:0]     last_rx,
    output logic [3:0]     fifo_cnt
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [15:0] DIV_4800  = 16'(CLK_FREQ / (16 * 4800) - 1);
    localparam logic [15:0] DIV_9600  = 16'(CLK_FREQ / (16 * 9600) - 1);
    localparam logic [15:0] DIV_19200 = 16'(CLK_FREQ / (16 * 19200) - 1);
    localparam logic [15:0] DIV_38400 = 16'(CLK_FREQ / (16 * 38400) - 1);

    typedef enum logic [2:0] {
        INIT_LO,
        INIT_HI,
        IDLE,
        RD,
        WR,
        GAP
    } state_t;

    state_t        state, state_d;
    state_t        ret_state, ret_d;

    logic [1:0]    cfg_s1, cfg_s2;
    logic [1:0]    cur_cfg;
    logic          reprog;
    logic          last_wr;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          push, pop;
    logic          rd_ok, wr_ok;
    logic [7:0]    rx_byte;
    logic [7:0]    head;

    logic          iocs_c, iorw_c, oe_c;
    logic [1:0]    addr_c;
    logic [7:0]    out_c;

    function automatic logic [15:0] divisor(input logic [1:0] cfg);
        case (cfg)
            2'b00:   return DIV_4800;
            2'b01:   return DIV_9600;
            2'b10:   return DIV_19200;
            default: return DIV_38400;
        endcase
    endfunction

    // Deliberately unreset: the synchronizer keeps sampling br_cfg during reset,
    // so the first divisor write after release already uses the switch setting.
    always_ff @(posedge clk) begin
        cfg_s1 <= br_cfg;
        cfg_s2 <= cfg_s1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_cfg <= '0;
        end else if (state == INIT_LO) begin
            cur_cfg <= cfg_s2;
        end
    end

    assign reprog = (cfg_s2 != cur_cfg);

`ifdef SPART_DRIVER_CASE_FOLD_EN
    assign rx_byte = (bus.bus_in >= 8'h61 && bus.bus_in <= 8'h7A) ? bus.bus_in - 8'h20 : bus.bus_in;
`else
    assign rx_byte = bus.bus_in;
`endif

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign fifo_cnt = 4'(count);
    assign rd_ok    = bus.rda & ~full;
    assign wr_ok    = bus.tbr & ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            last_rx <= '0;
        end else if (push) begin
            wr_ptr  <= wr_ptr + 1'b1;
            count   <= count + 1'b1;
            last_rx <= bus.bus_in;
        end else if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            count   <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT_LO;
            ret_state <= IDLE;
            last_wr   <= 1'b1;
        end else begin
            state     <= state_d;
            ret_state <= ret_d;
            if (push) begin
                last_wr <= 1'b0;
            end else if (pop) begin
                last_wr <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        ret_d   = ret_state;
        iocs_c  = 1'b0;
        iorw_c  = 1'b1;
        addr_c  = 2'b00;
        out_c   = 8'h00;
        oe_c    = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        case (state)
            INIT_LO: begin
                iocs_c  = 1'b1;
                iorw_c  = 1'b0;
                oe_c    = 1'b1;
                addr_c  = 2'b10;
                out_c   = divisor(cfg_s2)[7:0];
                state_d = GAP;
                ret_d   = INIT_HI;
            end
            INIT_HI: begin
                iocs_c  = 1'b1;
                iorw_c  = 1'b0;
                oe_c    = 1'b1;
                addr_c  = 2'b11;
                out_c   = divisor(cur_cfg)[15:8];
                state_d = GAP;
                ret_d   = IDLE;
            end
            IDLE: begin
                // When both are eligible, the access opposite to the last one wins.
                if (reprog) begin
                    state_d = INIT_LO;
                end else if (rd_ok && (!wr_ok || last_wr)) begin
                    state_d = RD;
                end else if (wr_ok) begin
                    state_d = WR;
                end
            end
            RD: begin
                iocs_c  = 1'b1;
                push    = 1'b1;
                state_d = GAP;
                ret_d   = IDLE;
            end
            WR: begin
                iocs_c  = 1'b1;
                iorw_c  = 1'b0;
                oe_c    = 1'b1;
                out_c   = head;
                pop     = 1'b1;
                state_d = GAP;
                ret_d   = IDLE;
            end
            GAP: begin
                state_d = ret_state;
            end
            default: begin
                state_d = INIT_LO;
            end
        endcase
    end

    // Reset gates the decoded bus outputs directly so an access in flight is abandoned at once.
    assign bus.iocs    = rst & iocs_c;
    assign bus.iorw    = ~rst | iorw_c;
    assign bus.ioaddr  = rst ? addr_c : 2'b00;
    assign bus.bus_out = rst ? out_c : 8'h00;
    assign bus.bus_oe  = rst & oe_c;

endmodule

// File: tb/tb_spart_driver.sv
// Testbench for spart_driver: directed scenarios plus random rda/tbr/data traffic,
// checked against a queue model of the echo path and a fixed divisor table.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic [7:0] last_rx;
    logic [3:0] fifo_cnt;

    spart_driver_if bus ();

    spart_driver #(
        .CLK_FREQ   (50000000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .bus      (bus),
        .last_rx  (last_rx),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [15:0] div_tab [4] = '{16'd650, 16'd324, 16'd161, 16'd80};

`ifdef SPART_DRIVER_CASE_FOLD_EN
    localparam logic [7:0] FOLD_61 = 8'h41;
`else
    localparam logic [7:0] FOLD_61 = 8'h61;
`endif

    logic [7:0] fifo_q [$];
    logic [7:0] exp_last   = 8'h00;
    logic       prev_iocs  = 1'b0;
    int         cfg_stable = 0;
    logic [1:0] prev_cfg   = 2'b00;
    logic       lo_ok      = 1'b0;
    logic [1:0] lo_cfg     = 2'b00;

    int   n, n_rd, n_wr, n_acc, n_alt;
    logic saw_rd, prev_kind, found;

    function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef SPART_DRIVER_CASE_FOLD_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input string tag, input logic [1:0] a, input logic rw, input int budget);
        int k = 0;
        while (!(bus.iocs === 1'b1 && bus.ioaddr === a && bus.iorw === rw) && k < budget) begin
            cyc();
            k++;
        end
        found = (bus.iocs === 1'b1 && bus.ioaddr === a && bus.iorw === rw);
        chk(tag, 32'(found), 1);
    endtask

    task automatic wait_cnt(input string tag, input logic [3:0] c, input int budget);
        int k = 0;
        while (fifo_cnt !== c && k < budget) begin
            cyc();
            k++;
        end
        chk(tag, 32'(fifo_cnt), 32'(c));
    endtask

    // Echo-path model: every observed read queues its (folded) byte, every write must carry the oldest one.
    always @(negedge clk) begin
        if (br_cfg === prev_cfg) cfg_stable++;
        else cfg_stable = 0;
        prev_cfg = br_cfg;
        if (!rst) begin
            fifo_q.delete();
            exp_last  = 8'h00;
            prev_iocs = 1'b0;
            lo_ok     = 1'b0;
        end else begin
            chk("fifo_cnt", 32'(fifo_cnt), 32'(fifo_q.size()));
            chk("last_rx", 32'(last_rx), 32'(exp_last));
            if (bus.iocs) begin
                chk("gap_before_access", 32'(prev_iocs), 0);
                chk("oe_on_write", 32'(bus.bus_oe), 32'(!bus.iorw));
                if (bus.ioaddr == 2'b00 && bus.iorw) begin
                    chk("rd_not_full", 32'(fifo_q.size() < 8), 1);
                    fifo_q.push_back(echo_of(bus.bus_in));
                    exp_last = bus.bus_in;
                end else if (bus.ioaddr == 2'b00) begin
                    chk("wr_not_empty", 32'(fifo_q.size() != 0), 1);
                    if (fifo_q.size() != 0) chk("wr_data", 32'(bus.bus_out), 32'(fifo_q.pop_front()));
                end else if (bus.ioaddr == 2'b10) begin
                    lo_ok = (cfg_stable >= 3);
                    lo_cfg = br_cfg;
                    if (lo_ok) chk("div_lo", 32'(bus.bus_out), 32'(div_tab[lo_cfg][7:0]));
                end else if (bus.ioaddr == 2'b11) begin
                    if (lo_ok) chk("div_hi", 32'(bus.bus_out), 32'(div_tab[lo_cfg][15:8]));
                end
            end
            prev_iocs = bus.iocs;
        end
    end

    initial begin
        rst        = 1'b0;
        br_cfg     = 2'b10;
        bus.rda    = 1'b0;
        bus.tbr    = 1'b1;
        bus.bus_in = 8'h00;
        repeat (3) cyc();
        chk("rst_iocs", 32'(bus.iocs), 0);
        chk("rst_iorw", 32'(bus.iorw), 1);
        chk("rst_ioaddr", 32'(bus.ioaddr), 0);
        chk("rst_bus_out", 32'(bus.bus_out), 0);
        chk("rst_bus_oe", 32'(bus.bus_oe), 0);
        chk("rst_last_rx", 32'(last_rx), 0);
        chk("rst_fifo_cnt", 32'(fifo_cnt), 0);

        // Reset release: divisor 161 = 0x00A1
        rst = 1'b1;
        #1;
        chk("init_lo_iocs", 32'(bus.iocs), 1);
        chk("init_lo_iorw", 32'(bus.iorw), 0);
        chk("init_lo_addr", 32'(bus.ioaddr), 2);
        chk("init_lo_data", 32'(bus.bus_out), 'hA1);
        chk("init_lo_oe", 32'(bus.bus_oe), 1);
        cyc();
        chk("init_gap", 32'(bus.iocs), 0);
        cyc();
        chk("init_hi_iocs", 32'(bus.iocs), 1);
        chk("init_hi_addr", 32'(bus.ioaddr), 3);
        chk("init_hi_data", 32'(bus.bus_out), 0);
        repeat (6) begin
            cyc();
            chk("idle_quiet", 32'(bus.iocs), 0);
        end

        // Single echo
        bus.bus_in = 8'h42;
        bus.rda    = 1'b1;
        wait_acc("echo_rd", 2'b00, 1'b1, 4);
        bus.rda = 1'b0;
        cyc();
        chk("echo_last_rx", 32'(last_rx), 'h42);
        chk("echo_cnt1", 32'(fifo_cnt), 1);
        chk("echo_gap", 32'(bus.iocs), 0);
        wait_acc("echo_wr", 2'b00, 1'b0, 4);
        chk("echo_wr_data", 32'(bus.bus_out), 'h42);
        chk("echo_wr_oe", 32'(bus.bus_oe), 1);
        cyc();
        chk("echo_cnt0", 32'(fifo_cnt), 0);

        // FIFO full: only 8 reads despite rda held high
        bus.tbr    = 1'b0;
        bus.rda    = 1'b1;
        bus.bus_in = 8'h01;
        n_rd = 0; n_acc = 0; saw_rd = 1'b0;
        repeat (40) begin
            cyc();
            if (saw_rd) begin
                bus.bus_in = bus.bus_in + 8'h01;
                saw_rd = 1'b0;
            end
            if (bus.iocs) n_acc++;
            if (bus.iocs && bus.iorw && bus.ioaddr == 2'b00) begin
                n_rd++;
                saw_rd = 1'b1;
            end
        end
        chk("full_rd_count", 32'(n_rd), 8);
        chk("full_acc_count", 32'(n_acc), 8);
        chk("full_cnt", 32'(fifo_cnt), 8);
        bus.rda = 1'b0;
        bus.tbr = 1'b1;
        n_wr = 0;
        repeat (40) begin
            cyc();
            if (bus.iocs && !bus.iorw) begin
                chk("full_drain_order", 32'(bus.bus_out), 32'(n_wr + 1));
                n_wr++;
            end
        end
        chk("full_drain_count", 32'(n_wr), 8);
        chk("full_drain_cnt", 32'(fifo_cnt), 0);

        // Round-robin with both eligible
        bus.tbr = 1'b0;
        bus.rda = 1'b1;
        n = 0;
        while (fifo_cnt != 4'd3 && n < 30) begin
            cyc();
            bus.bus_in = 8'($urandom);
            n++;
        end
        chk("alt_fill", 32'(fifo_cnt), 3);
        bus.tbr = 1'b1;
        prev_kind = 1'b1;
        n_alt = 0; n = 0;
        while (n_alt < 8 && n < 60) begin
            cyc();
            bus.bus_in = 8'($urandom);
            n++;
            if (bus.iocs) begin
                chk("alt_toggle", 32'(bus.iorw), 32'(!prev_kind));
                prev_kind = bus.iorw;
                n_alt++;
            end
        end
        chk("alt_count", 32'(n_alt), 8);
        bus.rda = 1'b0;
        wait_cnt("alt_drain", 4'd0, 40);

        // Baud change 10 -> 00 during a write
        bus.tbr = 1'b0;
        bus.rda = 1'b1;
        wait_cnt("bc_fill", 4'd2, 30);
        bus.rda = 1'b0;
        bus.tbr = 1'b1;
        wait_acc("bc_wr", 2'b00, 1'b0, 6);
        br_cfg  = 2'b00;
        bus.tbr = 1'b0;
        cyc();
        chk("bc_wr_done", 32'(fifo_cnt), 1);
        wait_acc("bc_div_lo", 2'b10, 1'b0, 6);
        chk("bc_lo", 32'(bus.bus_out), 'h8A);
        cyc();
        cyc();
        chk("bc_hi_addr", 32'(bus.ioaddr), 3);
        chk("bc_hi", 32'(bus.bus_out), 'h02);
        chk("bc_cnt_kept", 32'(fifo_cnt), 1);
        bus.tbr = 1'b1;
        wait_cnt("bc_drain", 4'd0, 20);

        // Case fold of 'a'
        bus.tbr    = 1'b0;
        bus.bus_in = 8'h61;
        bus.rda    = 1'b1;
        wait_acc("cf_rd", 2'b00, 1'b1, 6);
        bus.rda = 1'b0;
        cyc();
        chk("cf_last_rx", 32'(last_rx), 'h61);
        bus.tbr = 1'b1;
        wait_acc("cf_wr", 2'b00, 1'b0, 6);
        chk("cf_wr_data", 32'(bus.bus_out), 32'(FOLD_61));
        cyc();

        // Random traffic, first half mostly blocked on tbr so the FIFO fills
        for (int i = 0; i < 400; i++) begin
            cyc();
            bus.rda    = ($urandom_range(0, 3) != 0);
            bus.tbr    = (i < 200) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
            bus.bus_in = 8'($urandom);
            if (i % 100 == 50) br_cfg = 2'($urandom);
        end
        bus.rda = 1'b0;
        bus.tbr = 1'b1;
        wait_cnt("rand_drain", 4'd0, 100);
        repeat (10) cyc();

        // Reset in the middle of a write access
        bus.tbr = 1'b0;
        bus.rda = 1'b1;
        wait_cnt("mr_fill", 4'd1, 30);
        bus.rda = 1'b0;
        bus.tbr = 1'b1;
        wait_acc("mr_wr", 2'b00, 1'b0, 10);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_iocs", 32'(bus.iocs), 0);
        chk("mr_oe", 32'(bus.bus_oe), 0);
        chk("mr_cnt", 32'(fifo_cnt), 0);
        br_cfg = 2'b11;
        repeat (3) cyc();
        rst = 1'b1;
        #1;
        chk("mr_restart_iocs", 32'(bus.iocs), 1);
        chk("mr_restart_addr", 32'(bus.ioaddr), 2);
        chk("mr_restart_lo", 32'(bus.bus_out), 'h50);
        cyc();
        cyc();
        chk("mr_restart_hi", 32'(bus.bus_out), 'h00);
        repeat (4) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spart_driver.md
Name: spart_driver

Overview:
- Bus master that sits directly upstream of the SPART on the SPART processor-side bus.
- After reset it programs the SPART baud divisor from the board switch baud select.
- It then polls the SPART status, reads every received byte into an 8-deep echo FIFO, and writes FIFO bytes back to the SPART transmit buffer. The result is a serial echo loop.
- It reprograms the divisor whenever the baud select changes.

Parameters:
- CLK_FREQ, 50000000: clock frequency in Hz; used for divisor computation.
- FIFO_DEPTH, 8: echo FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  asynchronous active-low reset
- br_cfg  input  2  baud select from switches (asynchronous to clk)
- rda  input  1  SPART receive data available
- tbr  input  1  SPART transmit buffer ready
- iocs  output  1  SPART chip select; one cycle per access
- iorw  output  1  1 = read, 0 = write
- ioaddr  output  2  00 = TX/RX buffer, 01 = status, 10 = divisor low, 11 = divisor high
- bus_in  input  8  SPART read data, valid combinationally while iocs&iorw
- bus_out  output  8  write data
- bus_oe  output  1  drive enable for external tristate; high only on write cycles
- last_rx  output  8  last byte read from SPART (drives LEDs)
- fifo_cnt  output  4  current FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset (rst=0, asynchronous): outputs are forced to:
  - iocs=0, iorw=1, ioaddr=00, bus_out=0, bus_oe=0
  - last_rx=0, fifo_cnt=0
  - FIFO pointers cleared; state=INIT_LO
- br_cfg passes through a 2-flop synchronizer. The reset value of the synchronizer tracks the first sampled br_cfg, so no spurious change is seen.
- Divisor is floor(CLK_FREQ/(16*baud)) - 1. At 50 MHz:
  - 00 = 4800 baud, divisor 650 (0x028A)
  - 01 = 9600 baud, divisor 324 (0x0144)
  - 10 = 19200 baud, divisor 161 (0x00A1)
  - 11 = 38400 baud, divisor 80 (0x0050)
- Every access is exactly one cycle with iocs=1, followed by one GAP cycle with iocs=0 so SPART status can settle. Back-to-back iocs is never allowed.
- States:
  - INIT_LO: write ioaddr=10, bus_out = divisor[7:0]; then GAP, then INIT_HI.
  - INIT_HI: write ioaddr=11, bus_out = divisor[15:8]; then GAP, then IDLE.
  - IDLE: arbitration between RD and WR:
    - a read is eligible if rda=1 and FIFO is not full;
    - a write is eligible if tbr=1 and FIFO is not empty;
    - if both are eligible, round-robin: the opposite of the last performed access wins; after reset, read wins;
    - if neither is eligible, stay in IDLE.
  - RD: iocs=1, iorw=1, ioaddr=00. Capture bus_in into the FIFO and into last_rx at the end of the cycle. Then GAP.
  - WR: iocs=1, iorw=0, ioaddr=00, bus_oe=1, bus_out = FIFO head. Pop at the end of the cycle. Then GAP.
  - GAP: one idle cycle, then go to the pending next state.
- FIFO:
  - pointers wrap modulo FIFO_DEPTH; full/empty are derived from the count;
  - push and pop never occur in the same cycle;
  - FIFO is never written when full, so overflow is impossible (SPART overruns internally instead);
  - FIFO is never popped when empty.
- Baud change:
  - a synchronized br_cfg differing from the latched value sets a reprogram flag;
  - the flag is honoured only from IDLE, so an in-flight access plus its GAP completes first;
  - on reprogram: latch the new br_cfg, go to INIT_LO; FIFO contents are preserved.
- Reset mid-access: iocs and bus_oe drop immediately (asynchronously); the state machine restarts at INIT_LO.

Optional Feature:
- Macro: SPART_DRIVER_CASE_FOLD_EN.
- When defined, received bytes 0x61..0x7A ('a'..'z') have 0x20 subtracted before entering the FIFO. last_rx always holds the raw byte.
- When undefined, bytes are echoed unmodified.

Test Plan:
- Reset release with br_cfg=10:
  - first cycle: iocs with ioaddr=10, bus_out=0xA1, bus_oe=1;
  - two cycles later: ioaddr=11, bus_out=0x00;
  - then no iocs while rda=0 and tbr=1.
- Single echo: rda=1 with bus_in=0x42, tbr=1:
  - RD cycle, last_rx=0x42, fifo_cnt=1;
  - GAP, then WR cycle with bus_out=0x42, bus_oe=1;
  - fifo_cnt returns to 0.
- FIFO full: tbr=0, rda held high, bus_in=0x01..0x0A:
  - exactly 8 RD cycles, fifo_cnt=8, no further iocs;
  - raise tbr: 8 WR cycles carry 0x01..0x08 in order.
- Simultaneous rda and tbr with 3 bytes queued: RD and WR accesses alternate, each separated by a GAP; iocs is never high two cycles in a row.
- br_cfg 10→00 during a WR access: the WR completes, then divisor writes 0x8A and 0x02 follow; the FIFO count is unchanged.
- With SPART_DRIVER_CASE_FOLD_EN, bus_in=0x61 gives WR bus_out=0x41 and last_rx=0x61; without the macro, bus_out=0x61.
